// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer: state encoding, address type, reset vector.
package fetch_sequencer_pkg;

  localparam int unsigned ADDR_WIDTH = 32;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam addr_t RESET_PC   = 32'hbfc0_0000;
  localparam addr_t INST_BYTES = 32'd4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_EXEC = 2'd3
  } fetch_state_t;

  function automatic addr_t word_align(input addr_t a);
    return {a[ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction fetch bus: one request/accept handshake and one response per accepted request.
interface fetch_sequencer_if;
  import fetch_sequencer_pkg::*;

  logic        ireq_valid;
  addr_t       ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;

  modport master (
    output ireq_valid, ireq_addr,
    input  ireq_ready, iresp_valid, iresp_data
  );

  modport slave (
    input  ireq_valid, ireq_addr,
    output ireq_ready, iresp_valid, iresp_data
  );

endinterface

// File: rtl/fetch_sequencer_npc.sv
// fetch_npc: combinational next-PC / delayed-branch record update (redirect beats retire).
module fetch_npc
  import fetch_sequencer_pkg::*;
(
  input  addr_t pc,
  input  logic  delayed,
  input  addr_t delayed_pc,
  input  logic  retire_branch,
  input  addr_t retire_target,
  input  logic  redirect,
  input  addr_t redirect_pc,
  output addr_t next_pc,
  output logic  next_delayed,
  output addr_t next_delayed_pc
);

  // Priority: redirect, then a retiring branch (even in a delay slot), then a pending target.
  always_comb begin
    next_pc         = pc + INST_BYTES;
    next_delayed    = delayed;
    next_delayed_pc = delayed_pc;
    if (redirect) begin
      next_pc      = redirect_pc;
      next_delayed = 1'b0;
    end else if (retire_branch) begin
      next_delayed    = 1'b1;
      next_delayed_pc = retire_target;
    end else if (delayed) begin
      next_pc      = delayed_pc;
      next_delayed = 1'b0;
    end else begin
      next_pc = pc + INST_BYTES;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// CPU front end: owns the PC and delayed-branch record, fetches one instruction at a time.
// Optional FETCH_ADDR_CHECK_EN: a misaligned PC skips the bus and raises inst_adel.
module fetch_sequencer #(
  parameter fetch_sequencer_pkg::addr_t RESET_PC = fetch_sequencer_pkg::RESET_PC
) (
  input  logic                       clk,
  input  logic                       reset,
  fetch_sequencer_if.master          ibus,
  output logic                       inst_valid,
  output logic [31:0]                inst,
  output fetch_sequencer_pkg::addr_t inst_pc,
  output logic                       inst_in_ds,
  output logic                       inst_adel,
  input  logic                       inst_ready,
  input  logic                       retire,
  input  logic                       retire_branch,
  input  fetch_sequencer_pkg::addr_t retire_target,
  input  logic                       redirect,
  input  fetch_sequencer_pkg::addr_t redirect_pc
);
  import fetch_sequencer_pkg::*;

  fetch_state_t state_q, state_d;
  addr_t        pc_q, pc_d;
  logic         delayed_q, delayed_d;
  addr_t        delayed_pc_q, delayed_pc_d;
  logic         flush_q, flush_d;
  addr_t        fetch_addr_q, fetch_addr_d;
  logic [31:0]  inst_q, inst_d;
  addr_t        npc_pc;
  logic         npc_delayed;
  addr_t        npc_delayed_pc;
  logic         pc_upd_s;
  logic         ireq_valid_s;
  logic         inst_active_s;
`ifdef FETCH_ADDR_CHECK_EN
  logic         adel_q, adel_d;
  logic         addr_misaligned_s;
  assign addr_misaligned_s = (fetch_addr_q[1:0] != 2'b00);
`endif

  fetch_npc u_npc (
    .pc              (pc_q),
    .delayed         (delayed_q),
    .delayed_pc      (delayed_pc_q),
    .retire_branch   (retire_branch),
    .retire_target   (retire_target),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .next_pc         (npc_pc),
    .next_delayed    (npc_delayed),
    .next_delayed_pc (npc_delayed_pc)
  );

  // State register and architectural record.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      delayed_q    <= 1'b0;
      delayed_pc_q <= 32'h0;
      flush_q      <= 1'b0;
      fetch_addr_q <= RESET_PC;
      inst_q       <= 32'h0;
`ifdef FETCH_ADDR_CHECK_EN
      adel_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      delayed_q    <= delayed_d;
      delayed_pc_q <= delayed_pc_d;
      flush_q      <= flush_d;
      fetch_addr_q <= fetch_addr_d;
      inst_q       <= inst_d;
`ifdef FETCH_ADDR_CHECK_EN
      adel_q       <= adel_d;
`endif
    end
  end

  // Next state; fetch_addr_q holds the bus address stable while pc_q may already be redirected.
  always_comb begin
    state_d      = state_q;
    flush_d      = flush_q;
    fetch_addr_d = fetch_addr_q;
    inst_d       = inst_q;
    ireq_valid_s = 1'b0;
`ifdef FETCH_ADDR_CHECK_EN
    adel_d       = adel_q;
`endif
    pc_upd_s = redirect | ((state_q == S_EXEC) & retire);
    if (pc_upd_s) begin
      pc_d         = npc_pc;
      delayed_d    = npc_delayed;
      delayed_pc_d = npc_delayed_pc;
    end else begin
      pc_d         = pc_q;
      delayed_d    = delayed_q;
      delayed_pc_d = delayed_pc_q;
    end

    case (state_q)
      S_REQ: begin
`ifdef FETCH_ADDR_CHECK_EN
        if (addr_misaligned_s) begin
          if (redirect) begin
            fetch_addr_d = redirect_pc;
          end else begin
            state_d = S_HOLD;
            inst_d  = 32'h0;
            adel_d  = 1'b1;
          end
        end else begin
`endif
          ireq_valid_s = 1'b1;
          if (redirect) flush_d = 1'b1;
          else          flush_d = flush_q;
          if (ibus.ireq_ready) state_d = S_WAIT;
          else                 state_d = S_REQ;
`ifdef FETCH_ADDR_CHECK_EN
        end
`endif
      end
      S_WAIT: begin
        if (ibus.iresp_valid) begin
          if (flush_q | redirect) begin
            state_d      = S_REQ;
            flush_d      = 1'b0;
            fetch_addr_d = redirect ? redirect_pc : pc_q;
          end else begin
            state_d = S_HOLD;
            inst_d  = ibus.iresp_data;
`ifdef FETCH_ADDR_CHECK_EN
            adel_d  = 1'b0;
`endif
          end
        end else begin
          if (redirect) flush_d = 1'b1;
          else          flush_d = flush_q;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          state_d      = S_REQ;
          fetch_addr_d = redirect_pc;
        end else if (inst_ready) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_EXEC: begin
        if (redirect || retire) begin
          state_d      = S_REQ;
          fetch_addr_d = npc_pc;
        end else begin
          state_d = S_EXEC;
        end
      end
      default: begin
        state_d      = S_REQ;
        fetch_addr_d = pc_q;
      end
    endcase
  end

  assign inst_active_s   = (state_q == S_HOLD) || (state_q == S_EXEC);
  assign ibus.ireq_valid = ireq_valid_s;
  assign ibus.ireq_addr  = ireq_valid_s ? word_align(fetch_addr_q) : 32'h0;
  assign inst_valid      = (state_q == S_HOLD);
  assign inst            = inst_active_s ? inst_q : 32'h0;
  assign inst_pc         = inst_active_s ? pc_q : 32'h0;
  assign inst_in_ds      = inst_active_s & delayed_q;
`ifdef FETCH_ADDR_CHECK_EN
  assign inst_adel       = inst_active_s & adel_q;
`else
  assign inst_adel       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Table-driven bench for fetch_sequencer plus a hand-written misaligned-target sequence.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_in_ds;
  logic        inst_adel;
  logic        inst_ready;
  logic        retire;
  logic        retire_branch;
  logic [31:0] retire_target;
  logic        redirect;
  logic [31:0] redirect_pc;

  fetch_sequencer_if ibus ();

  fetch_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .ibus          (ibus),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_in_ds    (inst_in_ds),
    .inst_adel     (inst_adel),
    .inst_ready    (inst_ready),
    .retire        (retire),
    .retire_branch (retire_branch),
    .retire_target (retire_target),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc)
  );

  // ctl = {reset, ireq_ready, iresp_valid, inst_ready, retire, retire_branch, redirect}
  // e   = {ireq_valid, inst_valid, inst_in_ds, inst_adel}
  typedef struct {
    logic [6:0]  ctl;
    logic [31:0] data;
    logic [31:0] tgt;
    logic [31:0] rpc;
    logic [3:0]  e;
    logic [31:0] eaddr;
    logic [31:0] einst;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic [6:0] ctl, input logic [31:0] data, input logic [31:0] tgt,
                              input logic [31:0] rpc, input logic [3:0] e, input logic [31:0] eaddr,
                              input logic [31:0] einst, input logic [31:0] epc);
    vec_t v;
    v.ctl = ctl; v.data = data; v.tgt = tgt; v.rpc = rpc;
    v.e = e; v.eaddr = eaddr; v.einst = einst; v.epc = epc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then land on the following negedge.
  task automatic step(input logic [6:0] ctl, input logic [31:0] data, input logic [31:0] tgt,
                      input logic [31:0] rpc);
    reset            = ctl[6];
    ibus.ireq_ready  = ctl[5];
    ibus.iresp_valid = ctl[4];
    inst_ready       = ctl[3];
    retire           = ctl[2];
    retire_branch    = ctl[1];
    redirect         = ctl[0];
    ibus.iresp_data  = data;
    retire_target    = tgt;
    redirect_pc      = rpc;
    @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input logic [3:0] e, input logic [31:0] eaddr,
                            input logic [31:0] einst, input logic [31:0] epc);
    chk({tag, " ireq_valid"}, {31'h0, ibus.ireq_valid}, {31'h0, e[3]});
    chk({tag, " ireq_addr"},  ibus.ireq_addr, eaddr);
    chk({tag, " inst_valid"}, {31'h0, inst_valid}, {31'h0, e[2]});
    chk({tag, " inst_in_ds"}, {31'h0, inst_in_ds}, {31'h0, e[1]});
    chk({tag, " inst_adel"},  {31'h0, inst_adel}, {31'h0, e[0]});
    chk({tag, " inst"},       inst, einst);
    chk({tag, " inst_pc"},    inst_pc, epc);
  endtask

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_RST  = 7'b1000000;
  localparam logic [6:0] C_RDY  = 7'b0100000;
  localparam logic [6:0] C_RSP  = 7'b0010000;
  localparam logic [6:0] C_IRD  = 7'b0001000;
  localparam logic [6:0] C_RET  = 7'b0000100;
  localparam logic [6:0] C_BR   = 7'b0000110;
  localparam logic [6:0] C_RDR  = 7'b0000001;

  initial begin
    // reset and first fetch, response two cycles after acceptance
    vecs.push_back(mk(C_RST,  32'h0, 32'h0, 32'h0, 4'b1000, 32'hbfc0_0000, 32'h0, 32'h0));
    vecs.push_back(mk(C_RDY,  32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0));
    vecs.push_back(mk(C_NONE, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0));
    vecs.push_back(mk(C_RSP,  32'h1234_5678, 32'h0, 32'h0, 4'b0100, 32'h0, 32'h1234_5678, 32'hbfc0_0000));
    vecs.push_back(mk(C_NONE, 32'h0, 32'h0, 32'h0, 4'b0100, 32'h0, 32'h1234_5678, 32'hbfc0_0000));
    vecs.push_back(mk(C_IRD,  32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h1234_5678, 32'hbfc0_0000));
    vecs.push_back(mk(C_NONE, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h1234_5678, 32'hbfc0_0000));
    // move to 0x100, branch there to 0x200
    vecs.push_back(mk(C_RDR,  32'h0, 32'h0, 32'h100, 4'b1000, 32'h100, 32'h0, 32'h0));
    vecs.push_back(mk(C_RDY,  32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0));
    vecs.push_back(mk(C_RSP,  32'h1000_0001, 32'h0, 32'h0, 4'b0100, 32'h0, 32'h1000_0001, 32'h100));
    vecs.push_back(mk(C_IRD,  32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h1000_0001, 32'h100));
    vecs.push_back(mk(C_BR,   32'h0, 32'h200, 32'h0, 4'b1000, 32'h104, 32'h0, 32'h0));
    vecs.push_back(mk(C_RDY,  32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0));
    vecs.push_back(mk(C_RSP,  32'h2222_2222, 32'h0, 32'h0, 4'b0110, 32'h0, 32'h2222_2222, 32'h104));
    vecs.push_back(mk(C_IRD,  32'h0, 32'h0, 32'h0, 4'b0010, 32'h0, 32'h2222_2222, 32'h104));
    vecs.push_back(mk(C_RET,  32'h0, 32'h0, 32'h0, 4'b1000, 32'h200, 32'h0, 32'h0));
    vecs.push_back(mk(C_RDY,  32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0));
    vecs.push_back(mk(C_RSP,  32'h3333_3333, 32'h0, 32'h0, 4'b0100, 32'h0, 32'h3333_3333, 32'h200));
    vecs.push_back(mk(C_IRD,  32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h3333_3333, 32'h200));
    // branch in the delay slot: target 0x300 replaced by 0x400
    vecs.push_back(mk(C_BR,   32'h0, 32'h300, 32'h0, 4'b1000, 32'h204, 32'h0, 32'h0));
    vecs.push_back(mk(C_RDY,  32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0));
    vecs.push_back(mk(C_RSP,  32'h4444_4444, 32'h0, 32'h0, 4'b0110, 32'h0, 32'h4444_4444, 32'h204));
    vecs.push_back(mk(C_IRD,  32'h0, 32'h0, 32'h0, 4'b0010, 32'h0, 32'h4444_4444, 32'h204));
    vecs.push_back(mk(C_BR,   32'h0, 32'h400, 32'h0, 4'b1000, 32'h208, 32'h0, 32'h0));
    vecs.push_back(mk(C_RDY,  32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0));
    vecs.push_back(mk(C_RSP,  32'h5555_5555, 32'h0, 32'h0, 4'b0110, 32'h0, 32'h5555_5555, 32'h208));
    vecs.push_back(mk(C_IRD,  32'h0, 32'h0, 32'h0, 4'b0010, 32'h0, 32'h5555_5555, 32'h208));
    vecs.push_back(mk(C_RET,  32'h0, 32'h0, 32'h0, 4'b1000, 32'h400, 32'h0, 32'h0));
    vecs.push_back(mk(C_RDY,  32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0));
    vecs.push_back(mk(C_RSP,  32'h6666_6666, 32'h0, 32'h0, 4'b0100, 32'h0, 32'h6666_6666, 32'h400));
    vecs.push_back(mk(C_IRD,  32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h6666_6666, 32'h400));
    // branch pending, then redirect to 0x380 while waiting: response dropped, delayed cleared
    vecs.push_back(mk(C_BR,   32'h0, 32'h500, 32'h0, 4'b1000, 32'h404, 32'h0, 32'h0));
    vecs.push_back(mk(C_RDY,  32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0));
    vecs.push_back(mk(C_RDR,  32'h0, 32'h0, 32'h380, 4'b0000, 32'h0, 32'h0, 32'h0));
    vecs.push_back(mk(C_RSP,  32'hdead_beef, 32'h0, 32'h0, 4'b1000, 32'h380, 32'h0, 32'h0));
    vecs.push_back(mk(C_RDY,  32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0));
    vecs.push_back(mk(C_RSP,  32'h7777_7777, 32'h0, 32'h0, 4'b0100, 32'h0, 32'h7777_7777, 32'h380));
    vecs.push_back(mk(C_IRD,  32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h7777_7777, 32'h380));
    // redirect and branch retire together: redirect wins, branch forgotten
    vecs.push_back(mk(C_BR | C_RDR, 32'h0, 32'h600, 32'h180, 4'b1000, 32'h180, 32'h0, 32'h0));
    vecs.push_back(mk(C_RDY,  32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0));
    vecs.push_back(mk(C_RSP,  32'h8888_8888, 32'h0, 32'h0, 4'b0100, 32'h0, 32'h8888_8888, 32'h180));
    vecs.push_back(mk(C_IRD,  32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h8888_8888, 32'h180));
    vecs.push_back(mk(C_RET,  32'h0, 32'h0, 32'h0, 4'b1000, 32'h184, 32'h0, 32'h0));
    // redirect before acceptance: address held, fetch completes and is discarded
    vecs.push_back(mk(C_RDR,  32'h0, 32'h0, 32'h280, 4'b1000, 32'h184, 32'h0, 32'h0));
    vecs.push_back(mk(C_NONE, 32'h0, 32'h0, 32'h0, 4'b1000, 32'h184, 32'h0, 32'h0));
    vecs.push_back(mk(C_RDY,  32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0));
    vecs.push_back(mk(C_RSP,  32'h9999_9999, 32'h0, 32'h0, 4'b1000, 32'h280, 32'h0, 32'h0));
    vecs.push_back(mk(C_RDY,  32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0));
    vecs.push_back(mk(C_RSP,  32'haaaa_aaaa, 32'h0, 32'h0, 4'b0100, 32'h0, 32'haaaa_aaaa, 32'h280));
    // redirect from HOLD to the last word, then wrap to 0
    vecs.push_back(mk(C_RDR,  32'h0, 32'h0, 32'hffff_fffc, 4'b1000, 32'hffff_fffc, 32'h0, 32'h0));
    vecs.push_back(mk(C_RDY,  32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0));
    vecs.push_back(mk(C_RSP,  32'hbbbb_bbbb, 32'h0, 32'h0, 4'b0100, 32'h0, 32'hbbbb_bbbb, 32'hffff_fffc));
    vecs.push_back(mk(C_IRD,  32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'hbbbb_bbbb, 32'hffff_fffc));
    vecs.push_back(mk(C_RET,  32'h0, 32'h0, 32'h0, 4'b1000, 32'h0, 32'h0, 32'h0));
    // reset mid-fetch; late response ignored in S_REQ
    vecs.push_back(mk(C_RDY,  32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0));
    vecs.push_back(mk(C_RST,  32'h0, 32'h0, 32'h0, 4'b1000, 32'hbfc0_0000, 32'h0, 32'h0));
    vecs.push_back(mk(C_RSP,  32'hcccc_cccc, 32'h0, 32'h0, 4'b1000, 32'hbfc0_0000, 32'h0, 32'h0));

    foreach (vecs[i]) begin
      step(vecs[i].ctl, vecs[i].data, vecs[i].tgt, vecs[i].rpc);
      check_outs($sformatf("row%0d", i), vecs[i].e, vecs[i].eaddr, vecs[i].einst, vecs[i].epc);
    end

    // misaligned branch target 0x202 reached through a delay slot
    step(C_RDY, 32'h0, 32'h0, 32'h0);
    step(C_RSP, 32'h0000_1111, 32'h0, 32'h0);
    check_outs("adl_first", 4'b0100, 32'h0, 32'h0000_1111, 32'hbfc0_0000);
    step(C_IRD, 32'h0, 32'h0, 32'h0);
    step(C_BR,  32'h0, 32'h202, 32'h0);
    check_outs("adl_ds_req", 4'b1000, 32'hbfc0_0004, 32'h0, 32'h0);
    step(C_RDY, 32'h0, 32'h0, 32'h0);
    step(C_RSP, 32'h0000_2222, 32'h0, 32'h0);
    check_outs("adl_ds", 4'b0110, 32'h0, 32'h0000_2222, 32'hbfc0_0004);
    step(C_IRD, 32'h0, 32'h0, 32'h0);
    step(C_RET, 32'h0, 32'h0, 32'h0);
`ifdef FETCH_ADDR_CHECK_EN
    check_outs("adl_noreq", 4'b0000, 32'h0, 32'h0, 32'h0);
    step(C_RDY, 32'h0, 32'h0, 32'h0);
    check_outs("adl_hold", 4'b0101, 32'h0, 32'h0, 32'h202);
    step(C_IRD, 32'h0, 32'h0, 32'h0);
    check_outs("adl_exec", 4'b0001, 32'h0, 32'h0, 32'h202);
`else
    check_outs("adl_req", 4'b1000, 32'h200, 32'h0, 32'h0);
    step(C_RDY, 32'h0, 32'h0, 32'h0);
    step(C_RSP, 32'h0000_3333, 32'h0, 32'h0);
    check_outs("adl_hold", 4'b0100, 32'h0, 32'h0000_3333, 32'h202);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
